// File: rtl/dsp_loader_pkg.sv
// Shared types and constants for the DSP boot loader.
// Optional checksum trailer is enabled with DSP_LOADER_CKSUM_EN.
package dsp_loader_pkg;

  localparam int WORD_W = 16;

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_GO   = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CKSUM,
    ST_RUN,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Word assembler for the boot loader: pairs bytes into big-endian words,
// walks the write address upward, counts remaining words down and issues
// the one-cycle memory write strobe. The output address/data/select hold
// their values between writes.
module loader_word_asm
  import dsp_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_cnt,
  input  logic              take_hi,
  input  logic              take_lo,
  input  logic              sel,
  output logic              last_word,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata
);

  logic [ADDR_W-1:0] addr_cnt;
  logic [15:0]       remain;
  logic [7:0]        hi_byte;

  // The word in flight is the last one of the block.
  assign last_word = (remain == 16'd1);

  // Address/count counters, high-byte holding register and write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt  <= '0;
      remain    <= '0;
      hi_byte   <= '0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (load) begin
        addr_cnt <= load_addr;
        remain   <= load_cnt;
      end
      if (take_hi) begin
        hi_byte <= byte_in;
      end
      if (take_lo) begin
        mem_we    <= 1'b1;
        mem_sel   <= sel;
        mem_addr  <= addr_cnt;
        mem_wdata <= {hi_byte, byte_in};
        addr_cnt  <= addr_cnt + 1'b1;
        remain    <= remain - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_boot_loader.sv
// Boot loader top: decodes the framed byte stream, range-checks each block
// against the selected memory, drives the memory write ports through the
// word assembler and holds the DSP core in reset until GO.
// Define DSP_LOADER_CKSUM_EN to require a zero-sum checksum byte per block.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for a command byte
// ADDR_HI  | expecting start address high byte
// ADDR_LO  | expecting start address low byte
// CNT_HI   | expecting word count high byte
// CNT_LO   | expecting word count low byte, range check on accept
// DATA_HI  | expecting high byte of next word
// DATA_LO  | expecting low byte of next word, write on accept
// CKSUM    | expecting block checksum byte (checksum build only)
// RUN      | load complete, core released, terminal
// ERR      | protocol error, core held, terminal
module dsp_boot_loader
  import dsp_loader_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

`ifdef DSP_LOADER_CKSUM_EN
  localparam loader_state_t BLOCK_END = ST_CKSUM;
`else
  localparam loader_state_t BLOCK_END = ST_IDLE;
`endif

  loader_state_t state;
  logic          sel;
  logic [7:0]    addr_hi;
  logic [7:0]    addr_lo;
  logic [7:0]    cnt_hi;
  logic          accept;
  logic [15:0]   addr_full;
  logic [15:0]   cnt_full;
  logic [16:0]   span;
  logic [16:0]   depth_sel;
  logic          range_bad;
  logic          last_word;
  logic          load;
  logic          take_hi;
  logic          take_lo;
`ifdef DSP_LOADER_CKSUM_EN
  logic [7:0]    cksum;
  logic [7:0]    cksum_next;
`endif

  assign accept    = in_valid & in_ready;
  assign addr_full = {addr_hi, addr_lo};
  assign cnt_full  = {cnt_hi, in_data};

  // 17-bit span so a block running past the top of memory cannot wrap.
  assign span      = {1'b0, addr_full} + {1'b0, cnt_full};
  assign depth_sel = sel ? DMEM_DEPTH[16:0] : IMEM_DEPTH[16:0];
  assign range_bad = (span > depth_sel);

  assign load    = accept && (state == ST_CNT_LO);
  assign take_hi = accept && (state == ST_DATA_HI);
  assign take_lo = accept && (state == ST_DATA_LO);

`ifdef DSP_LOADER_CKSUM_EN
  assign cksum_next = cksum + in_data;
`endif

  // Frame decoder with registered handshake and core-control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      sel      <= 1'b0;
      addr_hi  <= '0;
      addr_lo  <= '0;
      cnt_hi   <= '0;
`ifdef DSP_LOADER_CKSUM_EN
      cksum    <= '0;
`endif
    end else begin
      in_ready <= (state != ST_RUN) && (state != ST_ERR);
      if (accept) begin
`ifdef DSP_LOADER_CKSUM_EN
        cksum <= cksum_next;
`endif
        case (state)
          ST_IDLE: begin
            if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
              state <= ST_ADDR_HI;
              sel   <= (in_data == CMD_DMEM);
`ifdef DSP_LOADER_CKSUM_EN
              cksum <= in_data;
`endif
            end else if (in_data == CMD_GO) begin
              state    <= ST_RUN;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end
          end
          ST_ADDR_HI: begin
            addr_hi <= in_data;
            state   <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            addr_lo <= in_data;
            state   <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            cnt_hi <= in_data;
            state  <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            if (range_bad) begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else if (cnt_full == 16'd0) begin
              state <= BLOCK_END;
            end else begin
              state <= ST_DATA_HI;
            end
          end
          ST_DATA_HI: begin
            state <= ST_DATA_LO;
          end
          ST_DATA_LO: begin
            state <= last_word ? BLOCK_END : ST_DATA_HI;
          end
`ifdef DSP_LOADER_CKSUM_EN
          ST_CKSUM: begin
            if (cksum_next == 8'h00) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  loader_word_asm #(
    .ADDR_W (ADDR_W)
  ) u_word_asm (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (in_data),
    .load      (load),
    .load_addr (addr_full[ADDR_W-1:0]),
    .load_cnt  (cnt_full),
    .take_hi   (take_hi),
    .take_lo   (take_lo),
    .sel       (sel),
    .last_word (last_word),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_dsp_boot_loader.sv
// Directed bench for dsp_boot_loader: basic load/run, stalled data block,
// bad command, range boundary, zero count, mid-frame reset and, when
// DSP_LOADER_CKSUM_EN is defined, checksum accept/reject.
module tb_dsp_boot_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic        mem_sel;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;
  int consec   = 0;
  logic prev_we = 1'b0;
  logic [7:0] fsum = 8'h00;
  logic [26:0] wr_q[$];

  dsp_boot_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe and flag back-to-back strobes.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_q.push_back({mem_sel, mem_addr, mem_wdata});
      if (prev_we) consec++;
    end
    prev_we = mem_we;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input int idx, input logic sel, input logic [9:0] addr, input logic [15:0] data);
    if (idx < wr_q.size()) chk("wr_entry", wr_q[idx], {sel, addr, data});
    else chk("wr_missing", wr_q.size(), idx + 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},   in_ready, 0);
    chk({tag, "_we"},    mem_we, 0);
    chk({tag, "_sel"},   mem_sel, 0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_hold"},  cpu_hold, 1);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   error, 0);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    fsum     = fsum + b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Closes a block frame; appends the zero-sum byte in the checksum build.
  task automatic blk_end();
`ifdef DSP_LOADER_CKSUM_EN
    logic [7:0] c;
    c = 8'h00 - fsum;
    send_byte(c);
`endif
    fsum = 8'h00;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b0;
    #3;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", in_ready, 1);
    wr_q.delete();
    consec = 0;
    fsum   = 8'h00;
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);

    // Basic InstrMem load then GO
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    chk("b_we1", mem_we, 1);
    send_byte(8'hAB); send_byte(8'hCD);
    chk("b_we2", mem_we, 1);
    chk("b_addr2", mem_addr, 10'h011);
    chk("b_data2", mem_wdata, 16'hABCD);
    blk_end();
    @(negedge clk);
    chk("b_we_low", mem_we, 0);
    chk("b_addr_hold", mem_addr, 10'h011);
    chk("b_hold_pre", cpu_hold, 1);
    send_byte(8'hFF);
    chk("b_hold", cpu_hold, 0);
    chk("b_done", done, 1);
    chk("b_rdy", in_ready, 0);
    chk("b_nwr", wr_q.size(), 2);
    chk_wr(0, 1'b0, 10'h010, 16'h1234);
    chk_wr(1, 1'b0, 10'h011, 16'hABCD);
    chk("b_consec", consec, 0);

    // DataMem block with in_valid toggling
    do_reset();
    send_byte(8'h02); @(negedge clk);
    send_byte(8'h00); @(negedge clk);
    send_byte(8'h00); @(negedge clk);
    send_byte(8'h00); @(negedge clk);
    send_byte(8'h01); @(negedge clk);
    send_byte(8'h00); @(negedge clk);
    send_byte(8'h05);
    chk("d_sel", mem_sel, 1);
    @(negedge clk);
    blk_end();
    repeat (3) @(negedge clk);
    chk("d_nwr", wr_q.size(), 1);
    chk_wr(0, 1'b1, 10'h000, 16'h0005);
    chk("d_hold", cpu_hold, 1);
    chk("d_done", done, 0);

    // Bad command
    do_reset();
    send_byte(8'h37);
    chk("e_err", error, 1);
    chk("e_rdy", in_ready, 0);
    chk("e_hold", cpu_hold, 1);
    repeat (2) @(negedge clk);
    chk("e_nwr", wr_q.size(), 0);

    // Range boundary: last word of InstrMem accepted
    do_reset();
    send_byte(8'h01); send_byte(8'h03); send_byte(8'hFF);
    send_byte(8'h00); send_byte(8'h01);
    chk("r_err_ok", error, 0);
    send_byte(8'hDE); send_byte(8'hAD);
    blk_end();
    @(negedge clk);
    chk("r_nwr", wr_q.size(), 1);
    chk_wr(0, 1'b0, 10'h3FF, 16'hDEAD);
    chk("r_err_after", error, 0);

    // Range boundary: one word too many
    do_reset();
    send_byte(8'h01); send_byte(8'h03); send_byte(8'hFF);
    send_byte(8'h00);
    chk("r2_err_pre", error, 0);
    send_byte(8'h02);
    chk("r2_err", error, 1);
    chk("r2_rdy", in_ready, 0);

    // Zero count then GO
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00);
    blk_end();
    send_byte(8'hFF);
    chk("z_done", done, 1);
    chk("z_hold", cpu_hold, 0);
    chk("z_nwr", wr_q.size(), 0);

    // Reset between DATA_HI and DATA_LO
    do_reset();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12);
    in_data  = 8'h34;
    in_valid = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    repeat (3) @(negedge clk);
    chk("mid_nwr", wr_q.size(), 0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rdy", in_ready, 1);
    chk("mid_nwr2", wr_q.size(), 0);

`ifdef DSP_LOADER_CKSUM_EN
    // Good checksum
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hFD);
    chk("c_err", error, 0);
    chk("c_rdy", in_ready, 1);
    chk_wr(0, 1'b0, 10'h000, 16'h0001);
    send_byte(8'hFF);
    chk("c_done", done, 1);

    // Bad checksum
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hFC);
    chk("c2_err", error, 1);
    chk("c2_nwr", wr_q.size(), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_boot_loader.md
# dsp_boot_loader

Hardware program loader that fills the DSP's instruction and data memories from a byte stream and holds the core in reset until loading completes. It does in silicon what the simulation bench does with file preloads: it decodes a framed byte protocol, drives the memories' write ports, then releases the core. It sits between the host byte link (UART receiver or similar) and the `dsp` top level's InstrMem and DataMem write ports and reset input.

## Interface
Parameters:
- `ADDR_W`, 10: memory address width.
- `IMEM_DEPTH`, 1024: instruction memory words; used for range check.
- `DMEM_DEPTH`, 1024: data memory words; used for range check.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  byte present.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid & in_ready`.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_sel`  out  1  target memory: 0 = InstrMem, 1 = DataMem.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  16  word, big-endian assembled.
- `cpu_hold`  out  1  core reset; high while loading.
- `done`  out  1  load complete; core running.
- `error`  out  1  protocol error latched.

## Operation
- Frame: CMD, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words of 2 bytes each (high byte first).
- CMD values:
  - 0x01: InstrMem block.
  - 0x02: DataMem block.
  - 0xFF: GO.
  - Any other value is an error.
- FSM states: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CKSUM (only when the macro is set), RUN, ERR.
- IDLE:
  - 0x01 or 0x02 → ADDR_HI. Latch `mem_sel`, clear the checksum accumulator.
  - 0xFF → RUN.
  - Any other byte → ERR.
- CNT_LO accept:
  - Range check: addr + cnt > depth of the selected memory → ERR. Use ADDR_W+1-bit arithmetic; no wrap.
  - cnt == 0 → IDLE (or CKSUM when the macro is set).
  - Otherwise → DATA_HI.
- DATA_LO accept:
  - Assemble the word and issue the write.
  - Increment the address and decrement the remaining count.
  - Remaining count reaches 0 → IDLE (or CKSUM when the macro is set).
  - Otherwise → DATA_HI.
- RUN: `cpu_hold`=0, `done`=1, `in_ready`=0. Terminal until reset.
- ERR: `error`=1, `cpu_hold`=1, `in_ready`=0. Terminal until reset.
- Writes already performed before an error are not undone.

## Timing
- Reset values:
  - `in_ready`=0, `mem_we`=0, `mem_sel`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_hold`=1, `done`=0, `error`=0.
  - FSM in IDLE.
- Reset assertion mid-frame: everything returns to reset values immediately, asynchronously.
- `in_ready` goes 1 in the first cycle after reset deassertion. It is registered and is 1 in every state except RUN and ERR.
- Throughput: one byte per cycle when `in_valid` is held high.
- Write latency: `mem_we` pulses for exactly one cycle, the cycle after DATA_LO is accepted. `mem_addr`, `mem_wdata` and `mem_sel` are valid during that cycle and hold afterwards until the next write.
- Back-to-back words: at most one write per 2 cycles; `mem_we` is never high two consecutive cycles.
- RUN entry: `cpu_hold` falls and `done` rises in the cycle after GO is accepted.
- ERR entry: `error` rises in the cycle after the offending byte is accepted.
- `in_valid` low in any state holds the state; there are no timeouts.

## Configuration
- `DSP_LOADER_CKSUM_EN` defined:
  - Each block frame (CMD 0x01/0x02) ends with one checksum byte.
  - The 8-bit sum of all frame bytes, including CMD and the checksum byte, must equal 0x00.
  - Match → IDLE. Mismatch → ERR.
- `DSP_LOADER_CKSUM_EN` undefined: there is no CKSUM state and frames end after the last data byte.
- GO never carries a checksum.

## Structure
- Shared package `dsp_loader_pkg`:
  - FSM state enum.
  - CMD constants `CMD_IMEM`, `CMD_DMEM`, `CMD_GO`.
  - `WORD_W` = 16.
- One natural sub-module, `loader_word_asm`: assembles the byte pair into a word, holds the address counter (increment) and the remaining-count down-counter, and produces the write strobe.
- FSM and range check live in `dsp_boot_loader`.

## Test plan
- Basic load and run: stream 01 00 10 00 02 12 34 AB CD, then FF.
  - Required: writes InstrMem[0x10]=0x1234 and InstrMem[0x11]=0xABCD, one-cycle `mem_we` each, `mem_sel`=0.
  - Required: `cpu_hold` drops and `done`=1 one cycle after FF.
- Data memory block with stalls: stream 02 00 00 00 01 00 05 with `in_valid` toggling every other cycle.
  - Required: a single write DataMem[0]=0x0005, `mem_sel`=1.
  - Required: no spurious `mem_we`; `cpu_hold` stays 1.
- Bad command: byte 0x37 in IDLE.
  - Required: `error`=1 next cycle, `in_ready`=0, `cpu_hold`=1, no writes.
- Range boundary: with `IMEM_DEPTH`=1024, send 01 03 FF 00 01 then one word.
  - Required: accepted, writes address 0x3FF.
  - Then, after reset, send 01 03 FF 00 02.
  - Required: ERR after CNT_LO.
- Zero count and mid-frame reset:
  - Send 01 00 00 00 00, then FF. Required: no writes, `done`=1.
  - Assert reset between DATA_HI and DATA_LO. Required: all outputs return to reset values, no write.
- With `DSP_LOADER_CKSUM_EN`:
  - Send 01 00 00 00 01 00 01 FD. Required: write, then IDLE.
  - Send checksum FC instead. Required: ERR after the write.
